// File: rtl/cache_pkg.sv
// cache_pkg: shared constants and FSM encoding for the cache miss/fill controller.
package cache_pkg;
    localparam int BLOCK_WORDS = 8;
    localparam int WORD_OFF_W  = $clog2(BLOCK_WORDS);
    localparam int BLOCK_OFF_W = WORD_OFF_W + 1;
    typedef enum logic [1:0] {IDLE, IFILL, DFILL, WRITE} state_t;
endpackage

// File: rtl/block_word_cnt.sv
// block_word_cnt: modulo-BLOCK_WORDS word counter; wrap flags the increment that completes the block.
module block_word_cnt
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [WORD_OFF_W-1:0] load_val,
    input  logic                  inc,
    output logic [WORD_OFF_W-1:0] cnt,
    output logic                  wrap
);
    logic [WORD_OFF_W-1:0] start_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt     <= '0;
            start_q <= '0;
        end else if (load) begin
            cnt     <= load_val;
            start_q <= load_val;
        end else if (inc)
            cnt <= cnt + 1'b1;
    // The block is complete when the next offset would return to where we started.
    assign wrap = inc && (WORD_OFF_W'(cnt + 1'b1) == start_q);
endmodule

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: arbitrates I-miss, D-miss and write-through requests and streams 8-word blocks into the caches.
// Define CACHE_FILL_CRITICAL_WORD_FIRST_EN to start each fill at the requested word and wrap within the block.
module cache_fill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              imiss_req,
    input  logic [ADDR_W-1:0] imiss_addr,
    input  logic              dmiss_req,
    input  logic [ADDR_W-1:0] dmiss_addr,
    input  logic              dwr_req,
    input  logic [ADDR_W-1:0] dwr_addr,
    input  logic [DATA_W-1:0] dwr_data,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic              fill_we,
    output logic              fill_sel,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              fill_done_i,
    output logic              fill_done_d,
    output logic              busy
);
    state_t                state, next_state;
    logic [ADDR_W-1:0]     addr_q, req_addr;
    logic [DATA_W-1:0]     wdata_q;
    logic                  done_pend, iss_act, start, fill, iss_inc, iss_wrap, rcv_wrap;
    logic [WORD_OFF_W-1:0] iss_cnt, rcv_cnt, start_off;

    assign req_addr = dwr_req ? dwr_addr : dmiss_req ? dmiss_addr : imiss_addr;
    assign start    = (state == IDLE) && (next_state != IDLE);
    assign fill     = (state == IFILL) || (state == DFILL);
    assign iss_inc  = fill && iss_act;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    assign start_off = req_addr[BLOCK_OFF_W-1:1];
`else
    assign start_off = '0;
`endif

    block_word_cnt u_iss_cnt (
        .clk(clk), .rst_n(rst_n), .load(start), .load_val(start_off),
        .inc(iss_inc), .cnt(iss_cnt), .wrap(iss_wrap)
    );
    block_word_cnt u_rcv_cnt (
        .clk(clk), .rst_n(rst_n), .load(start), .load_val(start_off),
        .inc(fill_we), .cnt(rcv_cnt), .wrap(rcv_wrap)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= next_state;

    // Store beats the D-miss, D-miss beats the I-miss: the MEM-stage instruction is older.
    always_comb
        next_state = (state == IDLE) ? (dwr_req ? WRITE : dmiss_req ? DFILL : imiss_req ? IFILL : IDLE)
                   : done_pend ? IDLE : state;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            iss_act   <= 1'b0;
            done_pend <= 1'b0;
        end else begin
            if (start) begin
                addr_q  <= req_addr;
                wdata_q <= dwr_data;
            end
            iss_act   <= start ? (next_state != WRITE) : iss_act && !iss_wrap;
            done_pend <= ((state == WRITE) && !done_pend) || rcv_wrap;
        end

    always_comb begin
        mem_wr      = (state == WRITE) && !done_pend;
        mem_en      = iss_inc || mem_wr;
        mem_addr    = mem_wr ? addr_q : iss_inc ? {addr_q[ADDR_W-1:BLOCK_OFF_W], iss_cnt, 1'b0} : '0;
        mem_wdata   = mem_wr ? wdata_q : '0;
        fill_we     = fill && mem_valid && !done_pend;
        fill_sel    = state == DFILL;
        fill_addr   = fill_we ? {addr_q[ADDR_W-1:BLOCK_OFF_W], rcv_cnt, 1'b0} : '0;
        fill_data   = fill_we ? mem_rdata : '0;
        fill_done_i = (state == IFILL) && done_pend;
        fill_done_d = ((state == DFILL) || (state == WRITE)) && done_pend;
        busy        = state != IDLE;
    end
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb_cache_fill_ctrl: randomized bench for cache_fill_ctrl with a transaction-level reference model.
// Honours CACHE_FILL_CRITICAL_WORD_FIRST_EN when computing the expected word order.
module tb_cache_fill_ctrl;
    typedef logic [63:0] ev_t;

    logic        clk = 0, rst_n = 0;
    logic        imiss_req = 0, dmiss_req = 0, dwr_req = 0;
    logic [15:0] imiss_addr = 0, dmiss_addr = 0, dwr_addr = 0, dwr_data = 0;
    logic        mem_en, mem_wr, mem_valid = 0;
    logic [15:0] mem_addr, mem_wdata, mem_rdata = 0;
    logic        fill_we, fill_sel, fill_done_i, fill_done_d, busy;
    logic [15:0] fill_addr, fill_data;

    int cyc = 0, n_chk = 0, n_fail = 0;
    int m0, f0, d0, b0;
    logic        rq_v [16] = '{default: 1'b0};
    logic [15:0] rq_addr [16] = '{default: 16'h0};
    logic        busy_prev = 0;
    ev_t mem_log[$], fill_log[$], done_log[$], busy_log[$];
    ev_t mem_exp[$], fill_exp[$], done_exp[$], busy_exp[$];

    cache_fill_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .imiss_req(imiss_req), .imiss_addr(imiss_addr),
        .dmiss_req(dmiss_req), .dmiss_addr(dmiss_addr),
        .dwr_req(dwr_req), .dwr_addr(dwr_addr), .dwr_data(dwr_data),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .fill_we(fill_we), .fill_sel(fill_sel), .fill_addr(fill_addr), .fill_data(fill_data),
        .fill_done_i(fill_done_i), .fill_done_d(fill_done_d), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mem_fn(logic [15:0] a);
        return (a * 16'd3) ^ 16'h5A5A;
    endfunction

    // Pipelined memory: a read seen in cycle c returns in cycle c+4.
    always @(posedge clk) begin
        #1;
        mem_valid = rq_v[(cyc + 12) % 16];
        mem_rdata = mem_valid ? mem_fn(rq_addr[(cyc + 12) % 16]) : 16'(~cyc);
    end

    always @(negedge clk) begin
        rq_v[cyc % 16]    = mem_en && !mem_wr;
        rq_addr[cyc % 16] = mem_addr;
        if (mem_en) mem_log.push_back({16'(cyc), 15'd0, mem_wr, mem_addr, mem_wr ? mem_wdata : 16'h0});
        if (fill_we) fill_log.push_back({16'(cyc), 15'd0, fill_sel, fill_addr, fill_data});
        if (fill_done_i || fill_done_d) done_log.push_back({16'(cyc), 46'd0, fill_done_i, fill_done_d});
        if (busy != busy_prev) busy_log.push_back({16'(cyc), 47'd0, busy});
        busy_prev = busy;
    end

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] word_addr(logic [15:0] a, int k);
        int s;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
        s = int'(a[3:1]);
`else
        s = 0;
`endif
        return {a[15:4], 4'h0} + 16'(2 * ((s + k) % 8));
    endfunction

    task automatic exp_fill(int e, logic [15:0] a, logic sel, int n_words, output int d);
        for (int k = 0; k < n_words; k++)
            mem_exp.push_back({16'(e + k), 15'd0, 1'b0, word_addr(a, k), 16'h0});
        for (int k = 0; k < 8; k++)
            fill_exp.push_back({16'(e + 4 + k), 15'd0, sel, word_addr(a, k), mem_fn(word_addr(a, k))});
        done_exp.push_back({16'(e + 12), 46'd0, !sel, sel});
        busy_exp.push_back({16'(e), 47'd0, 1'b1});
        busy_exp.push_back({16'(e + 13), 47'd0, 1'b0});
        d = e + 12;
    endtask

    task automatic exp_write(int e, logic [15:0] a, logic [15:0] data, output int d);
        mem_exp.push_back({16'(e), 15'd0, 1'b1, a, data});
        done_exp.push_back({16'(e + 1), 46'd0, 1'b0, 1'b1});
        busy_exp.push_back({16'(e), 47'd0, 1'b1});
        busy_exp.push_back({16'(e + 2), 47'd0, 1'b0});
        d = e + 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mark();
        m0 = mem_log.size(); f0 = fill_log.size(); d0 = done_log.size(); b0 = busy_log.size();
        mem_exp.delete(); fill_exp.delete(); done_exp.delete(); busy_exp.delete();
    endtask

    task automatic cmp_q(string tag, input ev_t got[$], input int base, input ev_t exp[$]);
        check({tag, "_count"}, 64'(got.size() - base), 64'(exp.size()));
        for (int i = 0; i < exp.size() && base + i < got.size(); i++)
            check($sformatf("%s[%0d]", tag, i), got[base + i], exp[i]);
    endtask

    task automatic compare(string tag);
        @(negedge clk);
        tick();
        cmp_q({tag, "_mem"}, mem_log, m0, mem_exp);
        cmp_q({tag, "_fill"}, fill_log, f0, fill_exp);
        cmp_q({tag, "_done"}, done_log, d0, done_exp);
        cmp_q({tag, "_busy"}, busy_log, b0, busy_exp);
    endtask

    task automatic run_combo(string tag, bit w, bit dm, bit im, logic [15:0] aw, logic [15:0] dw,
                             logic [15:0] ad, logic [15:0] ai, int drop);
        int r, e, dd, di, last;
        mark();
        r = cyc;
        dwr_req = w; dwr_addr = aw; dwr_data = dw;
        dmiss_req = dm; dmiss_addr = ad;
        imiss_req = im; imiss_addr = ai;
        e = r + 1; dd = -100; di = -100;
        if (w) begin exp_write(e, aw, dw, dd); e = dd + 2; end
        else if (dm) begin exp_fill(e, ad, 1'b1, 8, dd); e = dd + 2; end
        if (im) exp_fill(e, ai, 1'b0, 8, di);
        last = (dd > di) ? dd : di;
        while (cyc < last + 3) begin
            tick();
            if (cyc == r + 2) begin
                dwr_addr = 16'($urandom); dwr_data = 16'($urandom); dmiss_addr = 16'($urandom);
                if (!(w || dm)) imiss_addr = 16'($urandom);
            end
            if (cyc == dd + 1) begin dwr_req = 0; dmiss_req = 0; end
            if (cyc == di + 1) imiss_req = 0;
            if (drop > 0 && cyc == r + 1 + drop) begin dwr_req = 0; dmiss_req = 0; imiss_req = 0; end
        end
        compare(tag);
    endtask

    task automatic run_reset(logic [15:0] a);
        int e, unused_d;
        mark();
        e = cyc + 1;
        imiss_req = 1; imiss_addr = a;
        exp_fill(e, a, 1'b0, 6, unused_d);
        fill_exp = fill_exp[0:1];
        done_exp.delete();
        busy_exp[1] = {16'(e + 6), 47'd0, 1'b0};
        while (cyc < e + 6) tick();
        rst_n = 0; imiss_req = 0;
        #1;
        check("rst_async_outputs", {busy, mem_en, fill_we, fill_done_i, fill_done_d, mem_addr, fill_addr},
              64'h0);
        tick(); tick();
        rst_n = 1;
        repeat (6) tick();
        compare("reset_mid_fill");
    endtask

    initial begin
        #1;
        check("reset_outputs", {busy, mem_en, mem_wr, fill_we, fill_sel, fill_done_i, fill_done_d,
                                mem_addr, fill_addr, fill_data}, 64'h0);
        repeat (3) tick();
        rst_n = 1;
        tick();
        run_combo("imiss_0026", 0, 0, 1, 16'h0, 16'h0, 16'h0, 16'h0026, 0);
        run_combo("d_then_i", 0, 1, 1, 16'h0, 16'h0, 16'h1230, 16'h0040, 0);
        run_combo("write_0100", 1, 0, 0, 16'h0100, 16'hBEEF, 16'h0, 16'h0, 0);
        run_reset(16'h0026);
        tick();
        run_combo("dmiss_fffe", 0, 1, 0, 16'h0, 16'h0, 16'hFFFE, 16'h0, 0);
        run_combo("imiss_002a", 0, 0, 1, 16'h0, 16'h0, 16'h0, 16'h002A, 0);
        run_combo("write_then_i", 1, 0, 1, 16'h0102, 16'h1234, 16'h0, 16'h3338, 0);
        for (int n = 0; n < 30; n++) begin
            int kind, drop;
            kind = $urandom_range(0, 4);
            drop = (kind < 3 && $urandom_range(0, 1) == 1) ? $urandom_range(1, 10) : 0;
            run_combo($sformatf("rand%0d", n), kind == 2 || kind == 4, kind == 1 || kind == 3,
                      kind == 0 || kind == 3 || kind == 4, 16'($urandom), 16'($urandom),
                      16'($urandom), 16'($urandom), drop);
            repeat ($urandom_range(0, 3)) tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
